// File: rtl/fb_write_arbiter_pkg.sv
// Shared types for the framebuffer write arbiter: posted-write entry layout,
// pixel width and the per-cycle arbitration slot.
package fb_write_arbiter_pkg;

   localparam int PIXEL_WIDTH = 16;
   localparam int ADDR_WIDTH  = 12;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0]  addr;
      logic [PIXEL_WIDTH-1:0] data;
   } fifo_entry_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2
   } slot_e;

endpackage

// File: rtl/fb_write_arbiter_if.sv
// Bundles the SPI write strobe, scanout read handshake and framebuffer RAM port.
// The arbiter sits on the slave side; the surrounding system drives the master side.
interface fb_write_arbiter_if #(
   parameter int ADDR_W = 12
) ();

   logic                                        wr_strobe;
   logic [ADDR_W-1:0]                           wr_address;
   logic [fb_write_arbiter_pkg::PIXEL_WIDTH-1:0] wr_data;

   logic                                        rd_req;
   logic [ADDR_W-1:0]                           rd_address;
   logic                                        rd_grant;
   logic                                        rd_valid;
   logic [fb_write_arbiter_pkg::PIXEL_WIDTH-1:0] rd_data;

   logic [ADDR_W:0]                             mem_addr;
   logic                                        mem_we;
   logic [fb_write_arbiter_pkg::PIXEL_WIDTH-1:0] mem_wdata;
   logic [fb_write_arbiter_pkg::PIXEL_WIDTH-1:0] mem_rdata;

   modport slave (
      input  wr_strobe, wr_address, wr_data, rd_req, rd_address, mem_rdata,
      output rd_grant, rd_valid, rd_data, mem_addr, mem_we, mem_wdata
   );

   modport master (
      output wr_strobe, wr_address, wr_data, rd_req, rd_address, mem_rdata,
      input  rd_grant, rd_valid, rd_data, mem_addr, mem_we, mem_wdata
   );

endinterface

// File: rtl/fb_post_fifo.sv
// Posted-write FIFO: wrap-bit pointers, combinational head, and a push on a
// full FIFO is still taken when the head is popped in the same cycle.
module fb_post_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 28
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int PTR_W  = $clog2(DEPTH);
   localparam int PTR_W1 = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                    (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem_q[rd_ptr_q[PTR_W-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W1'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W1'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage is not reset; the pointers alone define validity.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= push_data;
   end

endmodule

// File: rtl/fb_write_arbiter.sv
// Arbitrates the single-port double-banked framebuffer between posted SPI writes
// and scanout reads, and owns front/back bank selection with vsync-timed swaps.
module fb_write_arbiter
   import fb_write_arbiter_pkg::*;
#(
   parameter int ADDRESS_BUS_WIDTH = ADDR_WIDTH,
   parameter int FRAME_WORDS       = 4096,
   parameter int FIFO_DEPTH        = 4,
   parameter int MAX_READ_STREAK   = 3
) (
   input  logic                     clk,
   input  logic                     rst_n,
   fb_write_arbiter_if.slave        bus,
   input  logic                     vsync,
   output logic                     front_bank,
   output logic                     swap_pending,
   output logic                     overflow
);

   localparam int STREAK_W = $clog2(MAX_READ_STREAK + 1);
   localparam logic [STREAK_W-1:0]   STREAK_MAX = STREAK_W'(MAX_READ_STREAK);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(FRAME_WORDS - 1);

   fifo_entry_t          push_entry;
   fifo_entry_t          head_entry;
   logic                 fifo_full;
   logic                 fifo_empty;
   slot_e                slot;

   logic [STREAK_W-1:0]  streak_q, streak_d;
   logic                 front_bank_q, front_bank_d;
   logic                 swap_pending_q, swap_pending_d;
   logic                 overflow_q, overflow_d;
   logic                 rd_valid_q;

   assign push_entry.addr = bus.wr_address;
   assign push_entry.data = bus.wr_data;

   fb_post_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(fifo_entry_t))
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (bus.wr_strobe),
      .push_data (push_entry),
      .pop       (slot == WRITE),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .head      (head_entry)
   );

   // Reads win unless they have already starved a pending write for a full streak.
   always_comb begin
      slot          = IDLE;
      bus.rd_grant  = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      if (!fifo_empty && (!bus.rd_req || streak_q == STREAK_MAX)) begin
         slot          = WRITE;
         bus.mem_we    = 1'b1;
         bus.mem_addr  = {~front_bank_q, head_entry.addr};
         bus.mem_wdata = head_entry.data;
      end else if (bus.rd_req) begin
         slot         = READ;
         bus.rd_grant = 1'b1;
         bus.mem_addr = {front_bank_q, bus.rd_address};
      end
   end

   always_comb begin
      streak_d       = streak_q;
      front_bank_d   = front_bank_q;
      swap_pending_d = swap_pending_q;
      overflow_d     = overflow_q | (bus.wr_strobe && fifo_full && slot != WRITE);

      if (slot == WRITE || fifo_empty)
         streak_d = '0;
      else if (slot == READ && streak_q != STREAK_MAX)
         streak_d = streak_q + STREAK_W'(1);

      if (vsync && swap_pending_q) begin
         front_bank_d   = ~front_bank_q;
         swap_pending_d = 1'b0;
      end
      // A completion landing on a vsync edge waits for the next vsync.
      if (slot == WRITE && head_entry.addr == LAST_ADDR)
         swap_pending_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         streak_q       <= '0;
         front_bank_q   <= 1'b0;
         swap_pending_q <= 1'b0;
         overflow_q     <= 1'b0;
         rd_valid_q     <= 1'b0;
      end else begin
         streak_q       <= streak_d;
         front_bank_q   <= front_bank_d;
         swap_pending_q <= swap_pending_d;
         overflow_q     <= overflow_d;
         rd_valid_q     <= bus.rd_grant;
      end
   end

   assign bus.rd_valid = rd_valid_q;
   assign bus.rd_data  = bus.mem_rdata;
   assign front_bank   = front_bank_q;
   assign swap_pending = swap_pending_q;
   assign overflow     = overflow_q;

endmodule
